// File: rtl/sq_window_accum.sv
// Sum of squares over a fixed window of 2^LOG2_N samples, fed by the 8x8 squarer, with a valid/ready result.
// Define SQ_WINDOW_PEAK_EN to add peak_o, the largest square seen in each reported window.
`timescale 1ns/1ps
module sq_window_accum #(
    parameter int MUL_LAT = 3,
    parameter int LOG2_N  = 4,
    parameter int SQ_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    input  logic [SQ_W-1:0]        sq_i,
    input  logic                   clear_i,
    output logic [SQ_W+LOG2_N-1:0] sum_o,
    output logic [SQ_W-1:0]        mean_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
`ifdef SQ_WINDOW_PEAK_EN
    output logic [SQ_W-1:0]        peak_o,
`endif
    output logic                   overrun_o
);

    localparam int ACC_W = SQ_W + LOG2_N;

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_e;

    state_e             state_q, state_d;
    logic [MUL_LAT-1:0] vld_q, vld_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LOG2_N-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    logic               v_al;
    logic               win_done;
    logic               load_res;
    logic [ACC_W-1:0]   win_sum;

    // The delay line tap lines in_valid_i up with the squarer output for the same sample.
    assign v_al     = vld_q[MUL_LAT-1];
    assign win_sum  = acc_q + ACC_W'(sq_i);
    assign win_done = v_al && (state_q == S_ACCUM) && (&cnt_q);
    assign load_res = win_done && (!out_valid_q || out_ready_i);

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        vld_d[0]    = in_valid_i;
        for (int i = 1; i < MUL_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        if (clear_i) begin
            vld_d       = '0;
            state_d     = S_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (v_al) begin
                case (state_q)
                    S_IDLE: begin
                        acc_d   = ACC_W'(sq_i);
                        cnt_d   = LOG2_N'(1);
                        state_d = S_ACCUM;
                    end
                    S_ACCUM: begin
                        if (&cnt_q) begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            acc_d = win_sum;
                            cnt_d = cnt_q + LOG2_N'(1);
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            // The result register is one deep: a finished window is dropped if the last is still unread.
            if (load_res) begin
                sum_d       = win_sum;
                out_valid_d = 1'b1;
            end else if (win_done) begin
                overrun_d = 1'b1;
            end else if (out_valid_q && out_ready_i) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vld_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sum_o       = sum_q;
    assign mean_o      = sum_q[ACC_W-1:LOG2_N];
    assign out_valid_o = out_valid_q;
    assign overrun_o   = overrun_q;

`ifdef SQ_WINDOW_PEAK_EN
    logic [SQ_W-1:0] max_q, max_d;
    logic [SQ_W-1:0] peak_q, peak_d;
    logic [SQ_W-1:0] sq_max;

    assign sq_max = (sq_i > max_q) ? sq_i : max_q;

    always_comb begin
        max_d  = max_q;
        peak_d = peak_q;
        if (clear_i) begin
            max_d = '0;
        end else begin
            if (v_al) begin
                if (state_q == S_IDLE) begin
                    max_d = sq_i;
                end else if (&cnt_q) begin
                    max_d = '0;
                end else begin
                    max_d = sq_max;
                end
            end
            if (load_res) begin
                peak_d = sq_max;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q  <= '0;
            peak_q <= '0;
        end else begin
            max_q  <= max_d;
            peak_q <= peak_d;
        end
    end

    assign peak_o = peak_q;
`endif

endmodule

// File: tb/tb_sq_window_accum.sv
// Directed bench for sq_window_accum; a small squarer pipeline model feeds sq_i from 8-bit samples.
`timescale 1ns/1ps
module tb_sq_window_accum;

    localparam int MUL_LAT = 3;
    localparam int LOG2_N  = 4;
    localparam int SQ_W    = 16;
    localparam int ACC_W   = SQ_W + LOG2_N;

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             in_valid_i  = 1'b0;
    logic             clear_i     = 1'b0;
    logic             out_ready_i = 1'b0;
    logic [SQ_W-1:0]  sq_i;
    logic [ACC_W-1:0] sum_o;
    logic [SQ_W-1:0]  mean_o;
    logic             out_valid_o;
    logic             overrun_o;
`ifdef SQ_WINDOW_PEAK_EN
    logic [SQ_W-1:0]  peak_o;
`endif

    logic [7:0]  sample = 8'd0;
    logic [7:0]  sq_pipe [MUL_LAT];
    logic [15:0] sq_src;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    // Stand-in for the squarer: the sample's square appears MUL_LAT cycles later.
    always @(posedge clk) begin
        sq_pipe[0] <= sample;
        for (int i = 1; i < MUL_LAT; i++) sq_pipe[i] <= sq_pipe[i-1];
    end
    assign sq_src = {8'h00, sq_pipe[MUL_LAT-1]};
    assign sq_i   = sq_src * sq_src;

    sq_window_accum #(.MUL_LAT(MUL_LAT), .LOG2_N(LOG2_N), .SQ_W(SQ_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .sq_i        (sq_i),
        .clear_i     (clear_i),
        .sum_o       (sum_o),
        .mean_o      (mean_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
`ifdef SQ_WINDOW_PEAK_EN
        .peak_o      (peak_o),
`endif
        .overrun_o   (overrun_o)
    );

    task automatic send(input logic [7:0] s);
        @(negedge clk);
        in_valid_i = 1'b1;
        sample     = s;
    endtask

    task automatic gap();
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            in_valid_i = 1'b0;
            if (out_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (sum_o !== 20'd0)      begin bad++; $display("FAIL reset_sum got=%0d exp=0", sum_o); end
        total++; if (mean_o !== 16'd0)     begin bad++; $display("FAIL reset_mean got=%0d exp=0", mean_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
        total++; if (overrun_o !== 1'b0)   begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        out_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) send(8'd3);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid_i = 1'b0;
            total++;
            if (out_valid_o !== (k == 4)) begin
                bad++; $display("FAIL basic_latency cycle=+%0d got=%b exp=%b", k, out_valid_o, (k == 4));
            end
        end
        total++; if (sum_o !== 20'd144)  begin bad++; $display("FAIL basic_sum got=%0d exp=144", sum_o); end
        total++; if (mean_o !== 16'd9)   begin bad++; $display("FAIL basic_mean got=%0d exp=9", mean_o); end
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%b exp=0", overrun_o); end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL basic_handshake got=%b exp=0", out_valid_o); end
        total++; if (sum_o !== 20'd144)    begin bad++; $display("FAIL basic_sum_hold got=%0d exp=144", sum_o); end
    endtask

    task automatic test_max();
        bit seen;
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) send(8'd255);
        wait_valid(10, seen);
        total++; if (!seen)                begin bad++; $display("FAIL max_timeout got=no_valid exp=valid"); end
        total++; if (sum_o !== 20'hFE010)  begin bad++; $display("FAIL max_sum got=%h exp=fe010", sum_o); end
        total++; if (mean_o !== 16'hFE01)  begin bad++; $display("FAIL max_mean got=%h exp=fe01", mean_o); end
        @(negedge clk);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL max_drop got=%b exp=0", out_valid_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_overrun();
        int extra;
        out_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) send(8'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid_i = 1'b0;
            total++;
            if (overrun_o !== (k == 4)) begin
                bad++; $display("FAIL ovr_flag cycle=+%0d got=%b exp=%b", k, overrun_o, (k == 4));
            end
        end
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", out_valid_o); end
        total++; if (sum_o !== 20'd16)     begin bad++; $display("FAIL ovr_sum_held got=%0d exp=16", sum_o); end
        total++; if (mean_o !== 16'd1)     begin bad++; $display("FAIL ovr_mean got=%0d exp=1", mean_o); end
        out_ready_i = 1'b1;
        @(negedge clk);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL ovr_handshake got=%b exp=0", out_valid_o); end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_o) extra++;
        end
        total++; if (extra !== 0)        begin bad++; $display("FAIL ovr_extra_result got=%0d exp=0", extra); end
        total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun_o); end
        out_ready_i = 1'b0;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL clr_overrun got=%b exp=0", overrun_o); end
        total++; if (sum_o !== 20'd16)   begin bad++; $display("FAIL clr_sum_kept got=%0d exp=16", sum_o); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int extra;
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) send(8'd7);
        @(negedge clk);
        in_valid_i = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (sum_o !== 20'd0)      begin bad++; $display("FAIL rstmid_sum got=%0d exp=0", sum_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid_o); end
        for (int i = 0; i < 16; i++) begin
            send(8'd2);
            if ($urandom_range(0, 1) == 1) gap();
        end
        wait_valid(10, seen);
        total++; if (!seen)            begin bad++; $display("FAIL rstmid_timeout got=no_valid exp=valid"); end
        total++; if (sum_o !== 20'd64) begin bad++; $display("FAIL rstmid_sum got=%0d exp=64", sum_o); end
        total++; if (mean_o !== 16'd4) begin bad++; $display("FAIL rstmid_mean got=%0d exp=4", mean_o); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_o) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL rstmid_extra_result got=%0d exp=0", extra); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b0;
        for (int k = 0; k < 32; k++) send(8'(k));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_valid_i = 1'b0;
            total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_first_valid cycle=+%0d got=%b exp=1", k, out_valid_o); end
            total++; if (sum_o !== 20'd1240)   begin bad++; $display("FAIL b2b_first_sum cycle=+%0d got=%0d exp=1240", k, sum_o); end
        end
        total++; if (mean_o !== 16'd77) begin bad++; $display("FAIL b2b_first_mean got=%0d exp=77", mean_o); end
        out_ready_i = 1'b1;
        @(negedge clk);
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b exp=1", out_valid_o); end
        total++; if (sum_o !== 20'd9176)   begin bad++; $display("FAIL b2b_second_sum got=%0d exp=9176", sum_o); end
        total++; if (mean_o !== 16'd573)   begin bad++; $display("FAIL b2b_second_mean got=%0d exp=573", mean_o); end
        total++; if (overrun_o !== 1'b0)   begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun_o); end
        @(negedge clk);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b exp=0", out_valid_o); end
        out_ready_i = 1'b0;
    endtask

`ifdef SQ_WINDOW_PEAK_EN
    task automatic test_peak();
        bit seen;
        out_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) send(8'(k));
        wait_valid(10, seen);
        total++; if (!seen)              begin bad++; $display("FAIL peak_timeout got=no_valid exp=valid"); end
        total++; if (peak_o !== 16'd225) begin bad++; $display("FAIL peak_first got=%0d exp=225", peak_o); end
        total++; if (sum_o !== 20'd1240) begin bad++; $display("FAIL peak_first_sum got=%0d exp=1240", sum_o); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) send(8'd20);
        @(negedge clk);
        in_valid_i = 1'b0;
        clear_i    = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        for (int i = 0; i < 16; i++) send(8'd5);
        wait_valid(10, seen);
        total++; if (!seen)             begin bad++; $display("FAIL peak2_timeout got=no_valid exp=valid"); end
        total++; if (sum_o !== 20'd400) begin bad++; $display("FAIL peak2_sum got=%0d exp=400", sum_o); end
        total++; if (peak_o !== 16'd25) begin bad++; $display("FAIL peak2_peak got=%0d exp=25", peak_o); end
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
`ifdef SQ_WINDOW_PEAK_EN
        test_peak();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
